branch_resolve: RTL

//   Stage directly downstream of compare. Latches n/z/sn from accepted CMP ops into an

---
 rtl/branch_resolve_pkg.sv | 43 ++++
 rtl/branch_resolve_if.sv | 28 ++
 rtl/branch_cond.sv | 27 ++
 rtl/branch_resolve.sv | 114 +++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolve stage: instruction encoding, flags and FSM states.
package branch_resolve_pkg;

  typedef logic [63:0] ulong_t;

  typedef enum logic [3:0] {
    NOP,
    ADD,
    SUB,
    CMP,
    JMP,
    JEQ,
    JNE,
    JLT,
    JGE,
    JSLT,
    JSGE
  } opcode_t;

  typedef struct packed {
    opcode_t op;
    ulong_t  arg0;
    ulong_t  arg1;
  } instruction_t;

  // n = unsigned less-than, z = equal, sn = signed less-than
  typedef struct packed {
    logic n;
    logic z;
    logic sn;
  } flags_t;

  typedef enum logic [1:0] {
    RUN,
    REDIRECT,
    FLUSH
  } brstate_t;

  function automatic logic is_branch(opcode_t op);
    return op inside {JMP, JEQ, JNE, JLT, JGE, JSLT, JSGE};
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Handshake bundle between the compare stage, fetch redirect and the downstream consumer.
interface branch_resolve_if;
  import branch_resolve_pkg::*;

  logic         in_valid;
  logic         in_ready;
  instruction_t in_instr;
  logic         cmp_n;
  logic         cmp_z;
  logic         cmp_sn;
  logic         out_valid;
  logic         out_ready;
  instruction_t out_instr;
  logic         redirect_valid;
  logic         redirect_ready;
  ulong_t       redirect_pc;

  modport master (
    output in_valid, in_instr, cmp_n, cmp_z, cmp_sn, out_ready, redirect_ready,
    input  in_ready, out_valid, out_instr, redirect_valid, redirect_pc
  );

  modport slave (
    input  in_valid, in_instr, cmp_n, cmp_z, cmp_sn, out_ready, redirect_ready,
    output in_ready, out_valid, out_instr, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch decode: classifies the opcode and evaluates its condition on the flags.
module branch_cond
  import branch_resolve_pkg::*;
(
  input  opcode_t op,
  input  flags_t  flags,
  output logic    branch,
  output logic    taken
);

  // Condition table; non-branch opcodes are never taken
  always_comb begin
    branch = is_branch(op);
    taken  = 1'b0;
    case (op)
      JMP:     taken = 1'b1;
      JEQ:     taken = flags.z;
      JNE:     taken = !flags.z;
      JLT:     taken = flags.n;
      JGE:     taken = !flags.n;
      JSLT:    taken = flags.sn;
      JSGE:    taken = !flags.sn;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve stage: holds architectural flags, resolves jumps, redirects fetch and
// discards the wrong-path instructions already in flight behind a taken branch.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  branch_resolve_if.slave   bus,
  output logic [2:0]        flags_q,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  ntaken_cnt
);

  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  brstate_t         state;
  brstate_t         state_nxt;
  flags_t           flags_r;
  logic [3:0]       flush_cnt;
  logic             in_ready_c;
  logic             accept;
  logic             br;
  logic             br_taken;
  logic             run_cmp;
  logic             run_fwd;
  logic             out_valid_r;
  instruction_t     out_instr_r;
  ulong_t           redirect_pc_r;
  logic [CNT_W-1:0] taken_r;
  logic [CNT_W-1:0] ntaken_r;

  branch_cond u_cond (
    .op     (bus.in_instr.op),
    .flags  (flags_r),
    .branch (br),
    .taken  (br_taken)
  );

  assign accept  = bus.in_valid && in_ready_c;
  assign run_cmp = (state == RUN) && accept && (bus.in_instr.op == CMP);
  assign run_fwd = (state == RUN) && accept && (bus.in_instr.op != CMP) && !br;

  // Next-state and handshake readiness; REDIRECT stalls input until fetch takes the target
  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    case (state)
      RUN: begin
        in_ready_c = !out_valid_r || bus.out_ready;
        if (accept && br && br_taken) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        if (bus.redirect_ready) state_nxt = (FLUSH_DEPTH == 0) ? RUN : FLUSH;
      end
      FLUSH: begin
        in_ready_c = 1'b1;
        if (accept && flush_cnt == 4'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // FSM, flags, redirect target, flush countdown and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      flags_r       <= '0;
      flush_cnt     <= '0;
      redirect_pc_r <= '0;
      taken_r       <= '0;
      ntaken_r      <= '0;
    end else begin
      state <= state_nxt;
      if (run_cmp) flags_r <= '{n: bus.cmp_n, z: bus.cmp_z, sn: bus.cmp_sn};
      if ((state == RUN) && accept && br) begin
        if (br_taken) begin
          redirect_pc_r <= bus.in_instr.arg0;
          taken_r       <= taken_r + CNT_ONE;
        end else begin
          ntaken_r <= ntaken_r + CNT_ONE;
        end
      end
      if (state == REDIRECT && bus.redirect_ready) flush_cnt <= FLUSH_INIT;
      else if (state == FLUSH && accept) flush_cnt <= flush_cnt - 4'd1;
    end
  end

  // One-entry output register; drains whenever downstream is ready, regardless of FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_instr_r <= '0;
    end else if (run_fwd) begin
      out_valid_r <= 1'b1;
      out_instr_r <= bus.in_instr;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.out_valid      = out_valid_r;
  assign bus.out_instr      = out_instr_r;
  assign bus.redirect_valid = (state == REDIRECT);
  assign bus.redirect_pc    = redirect_pc_r;
  assign flags_q            = flags_r;
  assign taken_cnt          = taken_r;
  assign ntaken_cnt         = ntaken_r;

endmodule
